// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl shared definitions: opcodes, funct codes, mux encodings,
// FSM state encodings and the instruction-class type.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [5:0] ALU_ADD  = 6'b100000;
    localparam logic [5:0] ALU_SUB  = 6'b100010;
    localparam logic [5:0] ALU_DEF  = 6'b111111;

    localparam logic [2:0] PCS_PC4  = 3'b000;
    localparam logic [2:0] PCS_RS   = 3'b001;
    localparam logic [2:0] PCS_BEQ  = 3'b010;
    localparam logic [2:0] PCS_BNE  = 3'b011;
    localparam logic [2:0] PCS_JMP  = 3'b100;

    localparam logic [1:0] SRCB_RT  = 2'b00;
    localparam logic [1:0] SRCB_4   = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_EXEC_R   = 4'd2;
    localparam logic [3:0] S_WB_R     = 4'd3;
    localparam logic [3:0] S_EXEC_I   = 4'd4;
    localparam logic [3:0] S_WB_I     = 4'd5;
    localparam logic [3:0] S_MEM_ADDR = 4'd6;
    localparam logic [3:0] S_MEM_RD   = 4'd7;
    localparam logic [3:0] S_MEM_WR   = 4'd8;
    localparam logic [3:0] S_WB_MEM   = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;
    localparam logic [3:0] S_JR       = 4'd12;
    localparam logic [3:0] S_TRAP     = 4'd13;

    typedef enum logic [2:0] {
        CLS_RTYPE,
        CLS_JR,
        CLS_ALUI,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_ILLEGAL
    } instr_cls_e;

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: IR fields and status in, enables,
// mux selects and debug status out.
interface mc_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       equal;
    logic       mem_ready;
    logic       PCWr;
    logic       IRWr;
    logic       RegWr;
    logic       MemRd;
    logic       MemWr;
    logic       IorD;
    logic       RegDst;
    logic       MemtoReg;
    logic       ExtOp;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [5:0] ALUCtr;
    logic [2:0] PCSrc;
    logic       instr_done;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  op, funct, equal, mem_ready,
        output PCWr, IRWr, RegWr, MemRd, MemWr, IorD, RegDst,
        output MemtoReg, ExtOp, ALUSrcA, ALUSrcB, ALUCtr, PCSrc,
        output instr_done, illegal, state
    );

    modport slave (
        output op, funct, equal, mem_ready,
        input  PCWr, IRWr, RegWr, MemRd, MemWr, IorD, RegDst,
        input  MemtoReg, ExtOp, ALUSrcA, ALUSrcB, ALUCtr, PCSrc,
        input  instr_done, illegal, state
    );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational op/funct classifier; also flags the immediate ops
// that need sign extension.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    output instr_cls_e o_cls,
    output logic       o_sext
);

    always_comb begin
        o_cls = CLS_ILLEGAL;
        case (i_op)
            OP_RTYPE: o_cls = (i_funct == FN_JR) ? CLS_JR : CLS_RTYPE;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI: o_cls = CLS_ALUI;
            OP_LW:    o_cls = CLS_LOAD;
            OP_SW:    o_cls = CLS_STORE;
            OP_BEQ, OP_BNE: o_cls = CLS_BRANCH;
            OP_J:     o_cls = CLS_JUMP;
            default:  o_cls = CLS_ILLEGAL;
        endcase
    end

    assign o_sext = (i_op == OP_ADDI) || (i_op == OP_SLTI);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM. Define MC_CTRL_TRAP_EN to send unknown
// instructions to a sticky TRAP state instead of executing them as NOPs.
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input logic        clk,
    input logic        rst,
    mc_ctrl_if.master  bus
);

    logic [3:0] r_state;
    logic [3:0] w_next;
    instr_cls_e w_cls;
    logic       w_sext;
    logic       w_pcwr, w_irwr, w_regwr, w_memrd, w_memwr, w_done;
    logic       w_iord, w_regdst, w_memtoreg, w_extop, w_srca;
    logic [1:0] w_srcb;
    logic [5:0] w_aluctr;
    logic [2:0] w_pcsrc;

    mc_ctrl_decode u_decode (
        .i_op    (bus.op),
        .i_funct (bus.funct),
        .o_cls   (w_cls),
        .o_sext  (w_sext)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    always_comb begin
        w_pcwr = 1'b0;  w_irwr = 1'b0;  w_regwr = 1'b0;
        w_memrd = 1'b0; w_memwr = 1'b0; w_done = 1'b0;
        w_iord = 1'b0;  w_regdst = 1'b0; w_memtoreg = 1'b0;
        w_extop = 1'b0; w_srca = 1'b0;  w_srcb = SRCB_RT;
        w_aluctr = ALU_DEF; w_pcsrc = PCS_PC4;
        w_next = S_FETCH;
        case (r_state)
            S_FETCH: begin
                w_memrd = 1'b1; w_srcb = SRCB_4; w_aluctr = ALU_ADD;
                w_pcwr = bus.mem_ready;
                w_irwr = bus.mem_ready;
                w_next = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                w_extop = 1'b1;
                case (w_cls)
                    CLS_RTYPE:  w_next = S_EXEC_R;
                    CLS_JR:     w_next = S_JR;
                    CLS_ALUI:   w_next = S_EXEC_I;
                    CLS_LOAD,
                    CLS_STORE:  w_next = S_MEM_ADDR;
                    CLS_BRANCH: w_next = S_BRANCH;
                    CLS_JUMP:   w_next = S_JUMP;
                    default: begin
`ifdef MC_CTRL_TRAP_EN
                        w_next = S_TRAP;
`else
                        w_next = S_FETCH;
                        w_done = 1'b1;
`endif
                    end
                endcase
            end
            S_EXEC_R: begin
                w_srca = 1'b1; w_aluctr = bus.funct; w_next = S_WB_R;
            end
            S_WB_R: begin
                w_regwr = 1'b1; w_regdst = 1'b1; w_done = 1'b1;
            end
            S_EXEC_I: begin
                w_srca = 1'b1; w_srcb = SRCB_IMM; w_aluctr = bus.op;
                w_extop = w_sext; w_next = S_WB_I;
            end
            S_WB_I: begin
                w_regwr = 1'b1; w_done = 1'b1;
            end
            S_MEM_ADDR: begin
                w_srca = 1'b1; w_srcb = SRCB_IMM; w_extop = 1'b1;
                w_aluctr = ALU_ADD;
                w_next = (w_cls == CLS_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                w_iord = 1'b1; w_memrd = 1'b1;
                w_next = bus.mem_ready ? S_WB_MEM : S_MEM_RD;
            end
            S_MEM_WR: begin
                w_iord = 1'b1; w_memwr = 1'b1;
                w_done = bus.mem_ready;
                w_next = bus.mem_ready ? S_FETCH : S_MEM_WR;
            end
            S_WB_MEM: begin
                w_regwr = 1'b1; w_memtoreg = 1'b1; w_done = 1'b1;
            end
            S_BRANCH: begin
                w_srca = 1'b1; w_aluctr = ALU_SUB; w_done = 1'b1;
                // BEQ takes the branch on equal, BNE on not-equal
                if (bus.op == OP_BEQ) begin
                    w_pcwr = bus.equal; w_pcsrc = PCS_BEQ;
                end else begin
                    w_pcwr = !bus.equal; w_pcsrc = PCS_BNE;
                end
            end
            S_JUMP: begin
                w_pcwr = 1'b1; w_pcsrc = PCS_JMP; w_done = 1'b1;
            end
            S_JR: begin
                w_pcwr = 1'b1; w_pcsrc = PCS_RS; w_done = 1'b1;
            end
`ifdef MC_CTRL_TRAP_EN
            S_TRAP: w_next = S_TRAP;
`endif
            default: w_next = S_FETCH;
        endcase
    end

    assign bus.PCWr       = w_pcwr  & ~rst;
    assign bus.IRWr       = w_irwr  & ~rst;
    assign bus.RegWr      = w_regwr & ~rst;
    assign bus.MemRd      = w_memrd & ~rst;
    assign bus.MemWr      = w_memwr & ~rst;
    assign bus.instr_done = w_done  & ~rst;
    assign bus.IorD       = w_iord;
    assign bus.RegDst     = w_regdst;
    assign bus.MemtoReg   = w_memtoreg;
    assign bus.ExtOp      = w_extop;
    assign bus.ALUSrcA    = w_srca;
    assign bus.ALUSrcB    = w_srcb;
    assign bus.ALUCtr     = w_aluctr;
    assign bus.PCSrc      = w_pcsrc;
    assign bus.state      = r_state;
`ifdef MC_CTRL_TRAP_EN
    assign bus.illegal    = (r_state == S_TRAP);
`else
    assign bus.illegal    = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-cycle expected control vectors are
// queued with their stimulus, then replayed and compared.
module tb_mc_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mc_ctrl_if bus ();

    mc_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        rs;
        logic        mr;
        logic        eq;
        logic [26:0] v;
    } ent_t;

    ent_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // {state, PCWr IRWr RegWr MemRd MemWr, IorD RegDst MemtoReg ExtOp,
    //  ALUSrcA, ALUSrcB, ALUCtr, PCSrc, instr_done, illegal}
    function automatic logic [26:0] ex(
        input logic [3:0] st, input logic [4:0] en,
        input logic [3:0] mx, input logic a, input logic [1:0] b,
        input logic [5:0] alu, input logic [2:0] pcs,
        input logic done, input logic ill);
        return {st, en, mx, a, b, alu, pcs, done, ill};
    endfunction

    function automatic logic [26:0] obs();
        return {bus.state, bus.PCWr, bus.IRWr, bus.RegWr, bus.MemRd,
                bus.MemWr, bus.IorD, bus.RegDst, bus.MemtoReg,
                bus.ExtOp, bus.ALUSrcA, bus.ALUSrcB, bus.ALUCtr,
                bus.PCSrc, bus.instr_done, bus.illegal};
    endfunction

    function automatic logic [26:0] fe(input logic mr);
        return ex(4'd0, {mr, mr, 3'b010}, 4'b0000, 1'b0, 2'b01,
                  6'b100000, 3'b000, 1'b0, 1'b0);
    endfunction

    function automatic logic [26:0] de(input logic done);
        return ex(4'd1, 5'b0, 4'b0001, 1'b0, 2'b00, 6'h3F, 3'b000,
                  done, 1'b0);
    endfunction

    function automatic ent_t mk(input logic rs, input logic mr,
                                input logic eq, input logic [26:0] v);
        ent_t e;
        e.rs = rs; e.mr = mr; e.eq = eq; e.v = v;
        return e;
    endfunction

    task automatic set_ir(input logic [5:0] o, input logic [5:0] f);
        bus.op = o;
        bus.funct = f;
    endtask

    task automatic test_reset();
        int k = 0;
        ent_t e;
        logic [26:0] got;
        set_ir(6'b100011, 6'b000000);
        q.push_back(mk(1, 1, 0, ex(4'd0, 5'b0, 4'b0000, 0, 2'b01,
                                   6'b100000, 3'b000, 0, 0)));
        q.push_back(mk(0, 1, 0, fe(1)));
        q.push_back(mk(0, 1, 0, de(0)));
        q.push_back(mk(0, 1, 0, ex(4'd6, 5'b0, 4'b0001, 1, 2'b10,
                                   6'b100000, 3'b000, 0, 0)));
        q.push_back(mk(0, 0, 0, ex(4'd7, 5'b00010, 4'b1000, 0, 2'b00,
                                   6'h3F, 3'b000, 0, 0)));
        q.push_back(mk(1, 0, 0, ex(4'd7, 5'b00000, 4'b1000, 0, 2'b00,
                                   6'h3F, 3'b000, 0, 0)));
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk);
            rst = e.rs; bus.mem_ready = e.mr; bus.equal = e.eq;
            #1 got = obs();
            checks++;
            if (got !== e.v) begin
                failures++;
                $display("FAIL reset cyc%0d got=%h exp=%h", k, got, e.v);
            end
            k++;
        end
    endtask

    task automatic test_rtype();
        int k = 0;
        ent_t e;
        logic [26:0] got;
        set_ir(6'b000000, 6'b100000);
        q.push_back(mk(0, 1, 0, fe(1)));
        q.push_back(mk(0, 1, 0, de(0)));
        q.push_back(mk(0, 1, 0, ex(4'd2, 5'b0, 4'b0000, 1, 2'b00,
                                   6'b100000, 3'b000, 0, 0)));
        q.push_back(mk(0, 1, 0, ex(4'd3, 5'b00100, 4'b0100, 0, 2'b00,
                                   6'h3F, 3'b000, 1, 0)));
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk);
            rst = e.rs; bus.mem_ready = e.mr; bus.equal = e.eq;
            #1 got = obs();
            checks++;
            if (got !== e.v) begin
                failures++;
                $display("FAIL add cyc%0d got=%h exp=%h", k, got, e.v);
            end
            k++;
        end
        k = 0;
        set_ir(6'b000000, 6'b100101);
        q.push_back(mk(0, 0, 0, fe(0)));
        q.push_back(mk(0, 1, 0, fe(1)));
        q.push_back(mk(0, 0, 0, de(0)));
        q.push_back(mk(0, 0, 0, ex(4'd2, 5'b0, 4'b0000, 1, 2'b00,
                                   6'b100101, 3'b000, 0, 0)));
        q.push_back(mk(0, 0, 0, ex(4'd3, 5'b00100, 4'b0100, 0, 2'b00,
                                   6'h3F, 3'b000, 1, 0)));
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk);
            rst = e.rs; bus.mem_ready = e.mr; bus.equal = e.eq;
            #1 got = obs();
            checks++;
            if (got !== e.v) begin
                failures++;
                $display("FAIL or_wait cyc%0d got=%h exp=%h", k, got, e.v);
            end
            k++;
        end
    endtask

    task automatic test_alui();
        int k = 0;
        ent_t e;
        logic [26:0] got;
        logic [5:0] ops [2];
        logic       sx  [2];
        ops[0] = 6'b001000; sx[0] = 1'b1;
        ops[1] = 6'b001101; sx[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            q.push_back(mk(0, 1, 0, fe(1)));
            q.push_back(mk(0, 1, 0, de(0)));
            q.push_back(mk(0, 1, 0, ex(4'd4, 5'b0, {3'b000, sx[i]}, 1,
                                       2'b10, ops[i], 3'b000, 0, 0)));
            q.push_back(mk(0, 1, 0, ex(4'd5, 5'b00100, 4'b0000, 0,
                                       2'b00, 6'h3F, 3'b000, 1, 0)));
            set_ir(ops[i], 6'b000000);
            while (q.size() > 0) begin
                e = q.pop_front();
                @(negedge clk);
                rst = e.rs; bus.mem_ready = e.mr; bus.equal = e.eq;
                #1 got = obs();
                checks++;
                if (got !== e.v) begin
                    failures++;
                    $display("FAIL alui%0d cyc%0d got=%h exp=%h",
                             i, k, got, e.v);
                end
                k++;
            end
        end
    endtask

    task automatic test_mem();
        int k = 0;
        ent_t e;
        logic [26:0] got;
        logic [26:0] mrd;
        mrd = ex(4'd7, 5'b00010, 4'b1000, 0, 2'b00, 6'h3F, 3'b000, 0, 0);
        set_ir(6'b100011, 6'b000000);
        q.push_back(mk(0, 1, 0, fe(1)));
        q.push_back(mk(0, 1, 0, de(0)));
        q.push_back(mk(0, 1, 0, ex(4'd6, 5'b0, 4'b0001, 1, 2'b10,
                                   6'b100000, 3'b000, 0, 0)));
        q.push_back(mk(0, 0, 0, mrd));
        q.push_back(mk(0, 0, 0, mrd));
        q.push_back(mk(0, 1, 0, mrd));
        q.push_back(mk(0, 1, 0, ex(4'd9, 5'b00100, 4'b0010, 0, 2'b00,
                                   6'h3F, 3'b000, 1, 0)));
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk);
            rst = e.rs; bus.mem_ready = e.mr; bus.equal = e.eq;
            #1 got = obs();
            checks++;
            if (got !== e.v) begin
                failures++;
                $display("FAIL lw cyc%0d got=%h exp=%h", k, got, e.v);
            end
            k++;
        end
        k = 0;
        set_ir(6'b101011, 6'b000000);
        q.push_back(mk(0, 1, 0, fe(1)));
        q.push_back(mk(0, 0, 0, de(0)));
        q.push_back(mk(0, 0, 0, ex(4'd6, 5'b0, 4'b0001, 1, 2'b10,
                                   6'b100000, 3'b000, 0, 0)));
        q.push_back(mk(0, 0, 0, ex(4'd8, 5'b00001, 4'b1000, 0, 2'b00,
                                   6'h3F, 3'b000, 0, 0)));
        q.push_back(mk(0, 1, 0, ex(4'd8, 5'b00001, 4'b1000, 0, 2'b00,
                                   6'h3F, 3'b000, 1, 0)));
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk);
            rst = e.rs; bus.mem_ready = e.mr; bus.equal = e.eq;
            #1 got = obs();
            checks++;
            if (got !== e.v) begin
                failures++;
                $display("FAIL sw cyc%0d got=%h exp=%h", k, got, e.v);
            end
            k++;
        end
    endtask

    task automatic test_branch();
        int k = 0;
        ent_t e;
        logic [26:0] got;
        logic [5:0] ops [3];
        logic       eqs [3];
        logic       tk  [3];
        logic [2:0] ps  [3];
        ops[0] = 6'b000100; eqs[0] = 0; tk[0] = 0; ps[0] = 3'b010;
        ops[1] = 6'b000101; eqs[1] = 0; tk[1] = 1; ps[1] = 3'b011;
        ops[2] = 6'b000100; eqs[2] = 1; tk[2] = 1; ps[2] = 3'b010;
        for (int i = 0; i < 3; i++) begin
            set_ir(ops[i], 6'b000000);
            q.push_back(mk(0, 1, eqs[i], fe(1)));
            q.push_back(mk(0, 1, eqs[i], de(0)));
            q.push_back(mk(0, 1, eqs[i], ex(4'd10, {tk[i], 4'b0000},
                           4'b0000, 1, 2'b00, 6'b100010, ps[i], 1, 0)));
            while (q.size() > 0) begin
                e = q.pop_front();
                @(negedge clk);
                rst = e.rs; bus.mem_ready = e.mr; bus.equal = e.eq;
                #1 got = obs();
                checks++;
                if (got !== e.v) begin
                    failures++;
                    $display("FAIL branch%0d cyc%0d got=%h exp=%h",
                             i, k, got, e.v);
                end
                k++;
            end
        end
    endtask

    task automatic test_jump();
        int k = 0;
        ent_t e;
        logic [26:0] got;
        logic [5:0] ops [2];
        logic [5:0] fns [2];
        logic [3:0] st  [2];
        logic [2:0] ps  [2];
        ops[0] = 6'b000010; fns[0] = 6'b000000; st[0] = 4'd11; ps[0] = 3'b100;
        ops[1] = 6'b000000; fns[1] = 6'b001000; st[1] = 4'd12; ps[1] = 3'b001;
        for (int i = 0; i < 2; i++) begin
            set_ir(ops[i], fns[i]);
            q.push_back(mk(0, 1, 0, fe(1)));
            q.push_back(mk(0, 1, 0, de(0)));
            q.push_back(mk(0, 1, 0, ex(st[i], 5'b10000, 4'b0000, 0,
                                       2'b00, 6'h3F, ps[i], 1, 0)));
            while (q.size() > 0) begin
                e = q.pop_front();
                @(negedge clk);
                rst = e.rs; bus.mem_ready = e.mr; bus.equal = e.eq;
                #1 got = obs();
                checks++;
                if (got !== e.v) begin
                    failures++;
                    $display("FAIL jump%0d cyc%0d got=%h exp=%h",
                             i, k, got, e.v);
                end
                k++;
            end
        end
    endtask

    task automatic test_illegal();
        int k = 0;
        ent_t e;
        logic [26:0] got;
        set_ir(6'b111111, 6'b000000);
        q.push_back(mk(0, 1, 0, fe(1)));
`ifdef MC_CTRL_TRAP_EN
        q.push_back(mk(0, 1, 0, de(0)));
        for (int i = 0; i < 12; i++)
            q.push_back(mk(0, 1, 0, ex(4'd13, 5'b0, 4'b0000, 0, 2'b00,
                                       6'h3F, 3'b000, 0, 1)));
        q.push_back(mk(1, 1, 0, ex(4'd13, 5'b0, 4'b0000, 0, 2'b00,
                                   6'h3F, 3'b000, 0, 1)));
`else
        q.push_back(mk(0, 1, 0, de(1)));
`endif
        q.push_back(mk(0, 0, 0, fe(0)));
        while (q.size() > 0) begin
            e = q.pop_front();
            @(negedge clk);
            rst = e.rs; bus.mem_ready = e.mr; bus.equal = e.eq;
            #1 got = obs();
            checks++;
            if (got !== e.v) begin
                failures++;
                $display("FAIL illegal cyc%0d got=%h exp=%h", k, got, e.v);
            end
            k++;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.mem_ready = 1'b0;
        bus.equal = 1'b0;
        set_ir(6'b000000, 6'b000000);
        @(posedge clk);
        test_reset();
        test_rtype();
        test_alui();
        test_mem();
        test_branch();
        test_jump();
        test_illegal();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
